// File: rtl/hub75_bcm_scan_if.sv
// HUB75 panel bus: pixel-fetch port toward the frame store plus the panel pins.
// The scanner drives through master; the frame store and panel side use slave.
interface hub75_bcm_scan_if #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 5,
    parameter int DEPTH    = 4
);
    localparam int CW = $clog2(COLS);

    logic [3*DEPTH-1:0] rgb1;
    logic [3*DEPTH-1:0] rgb2;
    logic [CW-1:0]       rd_col;
    logic [ROW_BITS-1:0] rd_row;
    logic [ROW_BITS-1:0] row_addr;
    logic CLK;
    logic LAT;
    logic OE;
    logic R1;
    logic G1;
    logic B1;
    logic R2;
    logic G2;
    logic B2;

    modport master (
        input  rgb1, rgb2,
        output rd_col, rd_row, row_addr, CLK, LAT, OE, R1, G1, B1, R2, G2, B2
    );

    modport slave (
        output rgb1, rgb2,
        input  rd_col, rd_row, row_addr, CLK, LAT, OE, R1, G1, B1, R2, G2, B2
    );
endinterface

// File: rtl/hub75_bcm_scan.sv
// HUB75 scan controller with binary-coded modulation: shifts one bit plane of a
// row pair, latches it, then lights it for BASE_ON<<plane cycles.
//
// state    | meaning
// IDLE     | panel blanked, waiting for enable
// SHIFT_LO | CLK low, capture next pixel bit onto data pins
// SHIFT_HI | CLK high, panel samples data pins
// BLANK    | one guard cycle after the last shift clock
// LATCH    | LAT high, row address presented
// DISPLAY  | OE low for the plane's weighted on-time
module hub75_bcm_scan #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 5,
    parameter int DEPTH    = 4,
    parameter int BASE_ON  = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic frame_start,
    hub75_bcm_scan_if.master bus
);
    localparam int CW     = $clog2(COLS);
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW     = $clog2(3 * DEPTH);
    localparam int MAX_ON = BASE_ON << (DEPTH - 1);
    localparam int TW     = $clog2(MAX_ON) + 1;

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       col;
    logic [PW-1:0]       plane;
    logic [ROW_BITS-1:0] row;
    logic [TW-1:0]       on_cnt;
    logic                last_col;
    logic                last_plane;
    logic                on_done;
    logic [IW-1:0]       idx_r;
    logic [IW-1:0]       idx_g;
    logic [IW-1:0]       idx_b;

    assign last_col   = (col == CW'(COLS - 1));
    assign last_plane = (plane == PW'(DEPTH - 1));
    assign on_done    = (on_cnt == '0);

    // Bit `plane` of the R, G and B fields inside the packed pixel word.
    assign idx_b = IW'(plane);
    assign idx_g = IW'(DEPTH) + IW'(plane);
    assign idx_r = IW'(2 * DEPTH) + IW'(plane);

    assign bus.rd_col = col;
    assign bus.rd_row = row;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (enable) state_nxt = SHIFT_LO;
            SHIFT_LO: state_nxt = SHIFT_HI;
            SHIFT_HI: state_nxt = last_col ? BLANK : SHIFT_LO;
            BLANK:    state_nxt = LATCH;
            LATCH:    state_nxt = DISPLAY;
            DISPLAY:  if (on_done) state_nxt = enable ? SHIFT_LO : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.CLK     = 1'b0;
        bus.LAT     = 1'b0;
        bus.OE      = 1'b1;
        frame_start = 1'b0;
        case (state)
            SHIFT_LO: frame_start = (col == '0) && (plane == '0) && (row == '0);
            SHIFT_HI: bus.CLK = 1'b1;
            LATCH:    bus.LAT = 1'b1;
            DISPLAY:  bus.OE  = 1'b0;
            default:  ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col          <= '0;
            plane        <= '0;
            row          <= '0;
            on_cnt       <= '0;
            bus.row_addr <= '0;
            bus.R1       <= 1'b0;
            bus.G1       <= 1'b0;
            bus.B1       <= 1'b0;
            bus.R2       <= 1'b0;
            bus.G2       <= 1'b0;
            bus.B2       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        col   <= '0;
                        plane <= '0;
                        row   <= '0;
                    end
                end
                SHIFT_LO: begin
                    bus.R1 <= bus.rgb1[idx_r];
                    bus.G1 <= bus.rgb1[idx_g];
                    bus.B1 <= bus.rgb1[idx_b];
                    bus.R2 <= bus.rgb2[idx_r];
                    bus.G2 <= bus.rgb2[idx_g];
                    bus.B2 <= bus.rgb2[idx_b];
                end
                SHIFT_HI: if (!last_col) col <= col + 1'b1;
                // Address moves on entry to LATCH so it only changes while blanked.
                BLANK:    bus.row_addr <= row;
                LATCH:    on_cnt <= TW'((BASE_ON << plane) - 1);
                DISPLAY: begin
                    if (!on_done) begin
                        on_cnt <= on_cnt - 1'b1;
                    end else begin
                        col <= '0;
                        if (last_plane) begin
                            plane <= '0;
                            row   <= row + 1'b1;
                        end else begin
                            plane <= plane + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Directed bench for hub75_bcm_scan with COLS=4, ROW_BITS=2, DEPTH=2, BASE_ON=2.
// Expected per-cycle panel timeline is derived from the row-plane phase sequence.
module tb_hub75_bcm_scan;
    localparam int COLS     = 4;
    localparam int ROW_BITS = 2;
    localparam int DEPTH    = 2;
    localparam int BASE_ON  = 2;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b0;
    logic frame_start;

    hub75_bcm_scan_if #(.COLS(COLS), .ROW_BITS(ROW_BITS), .DEPTH(DEPTH)) bus ();

    hub75_bcm_scan #(
        .COLS(COLS), .ROW_BITS(ROW_BITS), .DEPTH(DEPTH), .BASE_ON(BASE_ON)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .frame_start (frame_start),
        .bus         (bus.master)
    );

    always #5 clock = ~clock;

    logic       col_mode = 1'b0;
    logic [5:0] pat1 = 6'd0;
    logic [5:0] pat2 = 6'd0;
    logic [5:0] pix1 [4];
    logic [5:0] pix2 [4];

    // Asynchronous frame store: pixel follows rd_col in the same cycle.
    always_comb begin
        bus.rgb1 = col_mode ? pix1[bus.rd_col] : pat1;
        bus.rgb2 = col_mode ? pix2[bus.rd_col] : pat2;
    end

    typedef struct {
        logic [5:0] rgb1;
        logic [5:0] rgb2;
        logic [2:0] o1_p0;
        logic [2:0] o2_p0;
        logic [2:0] o1_p1;
        logic [2:0] o2_p1;
    } vec_t;

    vec_t vecs [4];

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int last_fs    = 0;
    int fs_gap     = 0;
    int ra_changes = 0;
    int ra_viol    = 0;
    logic [ROW_BITS-1:0] prev_ra = '0;

    always @(negedge clock) begin
        if (!reset && bus.row_addr != prev_ra) begin
            ra_changes++;
            if (bus.OE !== 1'b1) ra_viol++;
        end
        prev_ra = bus.row_addr;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_oe"},       int'(bus.OE), 1);
        chk({tag, "_clk"},      int'(bus.CLK), 0);
        chk({tag, "_lat"},      int'(bus.LAT), 0);
        chk({tag, "_data"},     int'({bus.R1, bus.G1, bus.B1, bus.R2, bus.G2, bus.B2}), 0);
        chk({tag, "_row_addr"}, int'(bus.row_addr), 0);
        chk({tag, "_rd_col"},   int'(bus.rd_col), 0);
        chk({tag, "_rd_row"},   int'(bus.rd_row), 0);
        chk({tag, "_fs"},       int'(frame_start), 0);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clock);
        check_idle("rst");
        reset = 1'b0;
        @(negedge clock);
        check_idle("post_rst");
    endtask

    // Walks one row-plane starting at its first SHIFT_LO cycle; returns at the
    // first cycle of whatever follows. e1/e2 hold the expected 3-bit data per column.
    task automatic row_plane(input logic [11:0] e1, input logic [11:0] e2, input int on,
                             input int row, input int fs_exp, input int drop_at);
        int n;
        n = 2 * COLS + 2 + on;
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) enable = 1'b0;
            if (i < 2 * COLS) begin
                chk("sh_clk", int'(bus.CLK), i % 2);
                chk("sh_oe",  int'(bus.OE), 1);
                chk("sh_lat", int'(bus.LAT), 0);
                chk("rd_col", int'(bus.rd_col), i / 2);
                chk("rd_row", int'(bus.rd_row), row);
                chk("frame_start", int'(frame_start), (i == 0) ? fs_exp : 0);
                if (i == 0 && frame_start) begin
                    fs_gap  = cyc - last_fs;
                    last_fs = cyc;
                end
                if (i % 2 == 1) begin
                    chk("data1", int'({bus.R1, bus.G1, bus.B1}), int'(e1[3*(i/2) +: 3]));
                    chk("data2", int'({bus.R2, bus.G2, bus.B2}), int'(e2[3*(i/2) +: 3]));
                end
            end else if (i == 2 * COLS) begin
                chk("blank_clk", int'(bus.CLK), 0);
                chk("blank_oe",  int'(bus.OE), 1);
                chk("blank_lat", int'(bus.LAT), 0);
            end else if (i == 2 * COLS + 1) begin
                chk("latch_lat",      int'(bus.LAT), 1);
                chk("latch_oe",       int'(bus.OE), 1);
                chk("latch_clk",      int'(bus.CLK), 0);
                chk("latch_row_addr", int'(bus.row_addr), row);
            end else begin
                chk("disp_oe",       int'(bus.OE), 0);
                chk("disp_lat",      int'(bus.LAT), 0);
                chk("disp_clk",      int'(bus.CLK), 0);
                chk("disp_row_addr", int'(bus.row_addr), row);
            end
            cyc++;
            @(negedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   found;
        int   n_fs;
        int   n_oe;
        int   n_clk;
        int   n_lat;

        vecs[0] = '{6'b10_01_11, 6'b01_10_00, 3'b011, 3'b100, 3'b101, 3'b010};
        vecs[1] = '{6'b11_11_11, 6'b00_00_00, 3'b111, 3'b000, 3'b111, 3'b000};
        vecs[2] = '{6'b00_00_00, 6'b11_00_01, 3'b000, 3'b101, 3'b000, 3'b100};
        vecs[3] = '{6'b01_10_10, 6'b10_01_01, 3'b100, 3'b011, 3'b011, 3'b100};

        pix1[0] = 6'b01_00_00; pix1[1] = 6'b00_01_00; pix1[2] = 6'b00_00_01; pix1[3] = 6'b10_10_10;
        for (int c = 0; c < 4; c++) pix2[c] = pix1[3 - c];

        // Constant-pixel vectors; each new reset lands mid-shift of the next row.
        for (int v = 0; v < 4; v++) begin
            pat1 = vecs[v].rgb1;
            pat2 = vecs[v].rgb2;
            do_reset();
            enable = 1'b1;
            @(negedge clock);
            row_plane({4{vecs[v].o1_p0}}, {4{vecs[v].o2_p0}}, 2, 0, 1, -1);
            row_plane({4{vecs[v].o1_p1}}, {4{vecs[v].o2_p1}}, 4, 0, 0, -1);
        end

        // Reset during DISPLAY, release with enable low.
        do_reset();
        enable = 1'b1;
        found  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (bus.OE == 1'b0) begin
                found = 1;
                break;
            end
        end
        chk("reach_display", found, 1);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_idle("idle_hold");
        end

        // Full frame with column-dependent pixels, then wrap to row 0.
        col_mode = 1'b1;
        do_reset();
        enable = 1'b1;
        @(negedge clock);
        for (int r = 0; r < 4; r++) begin
            row_plane(12'b000_001_010_100, 12'b100_010_001_000, 2, r, (r == 0) ? 1 : 0, -1);
            row_plane(12'b111_000_000_000, 12'b000_000_000_111, 4, r, 0, -1);
        end
        row_plane(12'b000_001_010_100, 12'b100_010_001_000, 2, 0, 1, -1);
        chk("fs_period", fs_gap, 104);

        // Drop enable mid-shift: the row-plane finishes, then IDLE stays blanked.
        col_mode = 1'b0;
        pat1 = vecs[0].rgb1;
        pat2 = vecs[0].rgb2;
        do_reset();
        enable = 1'b1;
        @(negedge clock);
        row_plane({4{vecs[0].o1_p0}}, {4{vecs[0].o2_p0}}, 2, 0, 1, 5);
        n_fs = 0; n_oe = 0; n_clk = 0; n_lat = 0;
        for (int k = 0; k < 30; k++) begin
            if (frame_start) n_fs++;
            if (!bus.OE)     n_oe++;
            if (bus.CLK)     n_clk++;
            if (bus.LAT)     n_lat++;
            @(negedge clock);
        end
        chk("drop_fs_pulses", n_fs, 0);
        chk("drop_oe_low",    n_oe, 0);
        chk("drop_clk_high",  n_clk, 0);
        chk("drop_lat_high",  n_lat, 0);

        // Re-enable restarts at row 0, plane 0.
        enable = 1'b1;
        @(negedge clock);
        row_plane({4{vecs[0].o1_p0}}, {4{vecs[0].o2_p0}}, 2, 0, 1, -1);

        chk("ra_changes_seen", int'(ra_changes != 0), 1);
        chk("ra_change_while_lit", ra_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hub75_bcm_scan.md
HUB75_BCM_SCAN -- requirements
Module: hub75_bcm_scan

Interface
REQ-001 Parameter COLS, 64, columns shifted per row; power of two, 2..256.
REQ-002 Parameter ROW_BITS, 5, row-address width; scan rows = 2**ROW_BITS.
REQ-003 Parameter DEPTH, 4, bit planes per colour channel (1..8).
REQ-004 Parameter BASE_ON, 8, display cycles of plane 0; plane p displays BASE_ON<<p cycles.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clock  in  1  system clock; every register updates on its rising edge.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 enable  in  1  run request.
REQ-009 rgb1  in  3*DEPTH  upper-half pixel {R[DEPTH-1:0],G[DEPTH-1:0],B[DEPTH-1:0]}.
REQ-010 rgb2  in  3*DEPTH  lower-half pixel, same packing as rgb1.
REQ-011 rd_col  out  log2(COLS)  pixel column being fetched.
REQ-012 rd_row  out  ROW_BITS  pixel row being fetched.
REQ-013 row_addr  out  ROW_BITS  panel row address (bit 0 = A, bit 1 = B, ...).
REQ-014 CLK, LAT  out  1 each  panel shift clock, panel latch.
REQ-015 OE  out  1  panel output enable, active-low (1 = blanked).
REQ-016 R1 G1 B1 R2 G2 B2  out  1 each  panel serial data.
REQ-017 frame_start  out  1  one-cycle pulse at frame start.

Function
REQ-018 States: IDLE, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY.
REQ-019 Pixel read is asynchronous: rgb1/rgb2 reflect rd_row/rd_col in the same cycle.
REQ-020 IDLE: OE=1, CLK=0, LAT=0; when enable=1, go to SHIFT_LO with col=0, plane=0, row=0.
REQ-021 SHIFT_LO: CLK=0; data pins register bit `plane` of each colour field from rgb1/rgb2 at rd_col; next state SHIFT_HI.
REQ-022 SHIFT_HI: CLK=1, data held; if col==COLS-1, go to BLANK, else col+1 and go to SHIFT_LO.
REQ-023 One pixel takes exactly 2 cycles; COLS rising CLK edges per row-plane; OE=1 throughout shifting.
REQ-024 BLANK (1 cycle): CLK=0, OE=1.
REQ-025 LATCH (1 cycle): row_addr<=current row, LAT=1, OE=1.
REQ-026 DISPLAY: LAT=0, OE=0 for exactly BASE_ON<<plane cycles; down-counter width covers BASE_ON<<(DEPTH-1).
REQ-027 End of DISPLAY: if plane<DEPTH-1, then plane+1, row unchanged; else plane=0 and row+1, wrapping 2**ROW_BITS-1 to 0.
REQ-028 End of DISPLAY with enable=1: go to SHIFT_LO, col=0. With enable=0: go to IDLE, OE=1.
REQ-029 enable changes are ignored outside IDLE and the last DISPLAY cycle; a row-plane is never truncated.
REQ-030 rd_row = row counter; rd_col = col counter.
REQ-031 frame_start=1 for exactly the first SHIFT_LO cycle in which row=0, plane=0, col=0.
REQ-032 row_addr changes only in LATCH, only while OE=1.
REQ-033 Row-plane period = 2*COLS + 2 + (BASE_ON<<plane) cycles.

Reset
REQ-034 With reset=1 at an edge, at the next edge: state=IDLE, OE=1, CLK=0, LAT=0, all data pins 0, row_addr=0, rd_col=0, rd_row=0, plane=0, frame_start=0.
REQ-035 Reset wins over every other condition, including mid-shift and mid-DISPLAY; no partial latch pulse follows.

Verification (COLS=4, ROW_BITS=2, DEPTH=2, BASE_ON=2)
REQ-036 Reset in DISPLAY, then release with enable=0 -> OE=1, CLK=0, LAT=0, outputs 0, remain IDLE.
REQ-037 enable=1, rgb1=6'b10_01_11 for all pixels -> plane 0: R1=0 G1=1 B1=1 over 4 CLK pulses; plane 1: R1=1 G1=0 B1=1.
REQ-038 Timing check -> plane 0 period 12 cycles (OE low 2), plane 1 period 14 cycles (OE low 4); LAT high 1 cycle before each OE-low window.
REQ-039 Run 8 row-planes -> row_addr sequence 0,0,1,1,2,2,3,3, then 0; frame_start pulses every 104 cycles.
REQ-040 Drop enable mid-shift -> current row-plane completes its DISPLAY, then IDLE with OE=1; frame_start does not pulse again.
REQ-041 Sweep rd_col during shift -> values 0,0,1,1,2,2,3,3 per SHIFT_LO/SHIFT_HI pair; rd_row equals the latched row.
